// File: rtl/ti_share_round_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ti_share_round_ctrl_if
// Handshake and coordinate-function bus of the two-share TI S-box sequencer.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface ti_share_round_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [3:0] in_rand;
    logic [7:0] cf_in;
    logic       cf_round;
    logic [7:0] cf_out;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       busy;

    modport slave (
        input  in_valid, in_data, in_rand, cf_out, out_ready,
        output in_ready, cf_in, cf_round, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, in_rand, cf_out, out_ready,
        input  in_ready, cf_in, cf_round, out_valid, out_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/ti_share_round_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ti_share_round_ctrl
// Masks a nibble into two shares, sequences two registered TI rounds through
// an external coordinate-function bank and recombines the result.
// Revision: 1.0
// ---------------------------------------------------------------------------
module ti_share_round_ctrl #(
    parameter int SETTLE = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ti_share_round_ctrl_if.slave    bus
);

    localparam logic [3:0] c_cnt_last = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_share;
    logic       r_round;
    logic [3:0] r_cnt;
    logic       r_in_ready;
    logic       r_out_valid;
    logic [3:0] r_out_data;
    logic       r_busy;

    // Every output is a flop so the S-box logic only ever sees glitch-free shares.
    assign bus.cf_in     = r_share;
    assign bus.cf_round  = r_round;
    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_share     <= 8'h00;
            r_round     <= 1'b0;
            r_cnt       <= 4'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= 4'h0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_share    <= {bus.in_rand, bus.in_data ^ bus.in_rand};
                        r_round    <= 1'b0;
                        r_cnt      <= 4'd0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_EVAL;
                    end
                end

                S_EVAL: begin
                    if (r_cnt == c_cnt_last) begin
                        r_share <= bus.cf_out;
                        r_cnt   <= 4'd0;
                        if (!r_round) begin
                            r_round <= 1'b1;
                        end else begin
                            // Result is latched once; shares stay masked in r_share.
                            r_out_valid <= 1'b1;
                            r_out_data  <= bus.cf_out[3:0] ^ bus.cf_out[7:4];
                            r_state     <= S_OUT;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end

                S_OUT: begin
                    if (bus.out_ready) begin
                        r_share     <= 8'h00;
                        r_round     <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_out_data  <= 4'h0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_share     <= 8'h00;
                    r_round     <= 1'b0;
                    r_cnt       <= 4'd0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_out_data  <= 4'h0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
